c7b_lsu: RTL and testbench

//  Single-outstanding load/store unit between execute control (ECL) and the bus interface unit (BIU).

---
 rtl/c7b_lsu_if.sv | 55 +++++
 rtl/c7b_lsu.sv | 263 ++++++++++++++++++++++++++
 tb/tb_c7b_lsu.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c7b_lsu_if.sv
// ----------------------------------------------------------------------------
// c7b_lsu_if
// Bus between the load/store unit and the bus interface unit (BIU).
//   master modport : LSU side (drives requests, receives acks and data)
//   slave modport  : BIU side (receives requests, drives acks and data)
// Signals
//   lsu_biu_rd_req_ls2 / lsu_biu_rd_addr_ls2     read request and byte address
//   biu_lsu_rd_ack_ls2                           read request accepted
//   biu_lsu_data_valid_ls3 / biu_lsu_data_ls3    read data (8-byte aligned doubleword)
//   lsu_biu_wr_req_ls2 / lsu_biu_wr_addr_ls2     write request and byte address
//   lsu_biu_wr_data_ls2 / lsu_biu_wr_strb_ls2    lane-replicated write data, byte strobes
//   biu_lsu_wr_ack_ls2                           write request accepted
//   biu_lsu_wr_done_ls3                          write completed
// ----------------------------------------------------------------------------
interface c7b_lsu_if;
    logic        lsu_biu_rd_req_ls2;
    logic [31:0] lsu_biu_rd_addr_ls2;
    logic        biu_lsu_rd_ack_ls2;
    logic        biu_lsu_data_valid_ls3;
    logic [63:0] biu_lsu_data_ls3;
    logic        lsu_biu_wr_req_ls2;
    logic [31:0] lsu_biu_wr_addr_ls2;
    logic [63:0] lsu_biu_wr_data_ls2;
    logic [7:0]  lsu_biu_wr_strb_ls2;
    logic        biu_lsu_wr_ack_ls2;
    logic        biu_lsu_wr_done_ls3;

    modport master (
        output lsu_biu_rd_req_ls2,
        output lsu_biu_rd_addr_ls2,
        input  biu_lsu_rd_ack_ls2,
        input  biu_lsu_data_valid_ls3,
        input  biu_lsu_data_ls3,
        output lsu_biu_wr_req_ls2,
        output lsu_biu_wr_addr_ls2,
        output lsu_biu_wr_data_ls2,
        output lsu_biu_wr_strb_ls2,
        input  biu_lsu_wr_ack_ls2,
        input  biu_lsu_wr_done_ls3
    );

    modport slave (
        input  lsu_biu_rd_req_ls2,
        input  lsu_biu_rd_addr_ls2,
        output biu_lsu_rd_ack_ls2,
        output biu_lsu_data_valid_ls3,
        output biu_lsu_data_ls3,
        input  lsu_biu_wr_req_ls2,
        input  lsu_biu_wr_addr_ls2,
        input  lsu_biu_wr_data_ls2,
        input  lsu_biu_wr_strb_ls2,
        output biu_lsu_wr_ack_ls2,
        output biu_lsu_wr_done_ls3
    );
endinterface

// File: rtl/c7b_lsu.sv
// ----------------------------------------------------------------------------
// c7b_lsu
// Single-outstanding load/store unit between execute control (ECL) and the BIU.
// Stages: E (issue) -> LS1 (address add, alignment check) -> LS2 (BIU request
// until ack) -> LS3 (wait for read data / write done).
// Ports
//   clk, resetn                 clock and synchronous active-low reset
//   ecl_lsu_*_e                 issue request: valid, op, base, offset, store data
//   lsu_ecl_data_valid_ls3      completion pulse (load data or store done)
//   lsu_ecl_data_ls3            extended load result, 0 for stores
//   lsu_ecl_except_ale_ls1      misaligned address, with lsu_csr_except_badv_ls1
//   lsu_ecl_except_buserr_ls3   bus error (LS3 timeout)
//   lsu_ecl_except_ecc_ls3      ECC error, reserved, always 0
//   biu                         c7b_lsu_if master modport
// Configuration
//   C7BLSU_BUSERR_TIMEOUT_EN    when defined, LS3 gives up after BUSERR_TIMEOUT
//                               cycles with a one-cycle bus error pulse; when
//                               undefined, LS3 waits indefinitely.
// ----------------------------------------------------------------------------
module c7b_lsu #(
    parameter int BUSERR_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ecl_lsu_valid_e,
    input  logic [6:0]  ecl_lsu_op_e,
    input  logic [31:0] ecl_lsu_base_e,
    input  logic [31:0] ecl_lsu_offset_e,
    input  logic [31:0] ecl_lsu_wdata_e,
    output logic        lsu_ecl_data_valid_ls3,
    output logic [31:0] lsu_ecl_data_ls3,
    output logic        lsu_ecl_except_ale_ls1,
    output logic [31:0] lsu_csr_except_badv_ls1,
    output logic        lsu_ecl_except_buserr_ls3,
    output logic        lsu_ecl_except_ecc_ls3,
    c7b_lsu_if.master   biu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LS1  = 2'd1,
        S_LS2  = 2'd2,
        S_LS3  = 2'd3
    } state_e;

    // op[3] = store, op[2] = unsigned load, op[1:0] = size (0 B, 1 H, 2 W)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_e      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [31:0] base_q, base_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_req_q, rd_req_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        wr_req_q, wr_req_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic [7:0]  wr_strb_q, wr_strb_d;

    logic        legal_op;
    logic        is_store;
    logic [1:0]  op_size;
    logic [31:0] ls1_addr;
    logic        misaligned;
    logic [7:0]  size_mask;
    logic [63:0] repl_data;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic        done_ls3;

    always_comb begin
        unique case (ecl_lsu_op_e)
            7'h00, 7'h01, 7'h02, 7'h04, 7'h05,
            7'h08, 7'h09, 7'h0A: legal_op = 1'b1;
            default:             legal_op = 1'b0;
        endcase
    end

    assign is_store = op_q[3];
    assign op_size  = op_q[1:0];
    assign ls1_addr = base_q + offset_q;

    assign misaligned = ((op_size == SZ_H) && ls1_addr[0]) ||
                        ((op_size == SZ_W) && (ls1_addr[1:0] != 2'b00));

    always_comb begin
        size_mask = 8'h01;
        repl_data = {8{wdata_q[7:0]}};
        if (op_size == SZ_H) begin
            size_mask = 8'h03;
            repl_data = {4{wdata_q[15:0]}};
        end else if (op_size == SZ_W) begin
            size_mask = 8'h0F;
            repl_data = {2{wdata_q}};
        end
    end

    // The BIU returns the whole aligned doubleword; the addressed bytes are
    // brought down to lane 0 before extension.
    assign lane = 32'(biu.biu_lsu_data_ls3 >> {addr_q[2:0], 3'b000});

    always_comb begin
        load_ext = lane;
        if (op_size == SZ_B) begin
            load_ext = {{24{lane[7] & ~op_q[2]}}, lane[7:0]};
        end else if (op_size == SZ_H) begin
            load_ext = {{16{lane[15] & ~op_q[2]}}, lane[15:0]};
        end
    end

    assign done_ls3 = is_store ? biu.biu_lsu_wr_done_ls3 : biu.biu_lsu_data_valid_ls3;

`ifdef C7BLSU_BUSERR_TIMEOUT_EN
    localparam int CNT_W = $clog2(BUSERR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSERR_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = BUSERR_TIMEOUT;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        base_d    = base_q;
        offset_d  = offset_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_strb_d = wr_strb_q;
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        lsu_ecl_data_valid_ls3    = 1'b0;
        lsu_ecl_data_ls3          = 32'h0;
        lsu_ecl_except_ale_ls1    = 1'b0;
        lsu_csr_except_badv_ls1   = 32'h0;
        lsu_ecl_except_buserr_ls3 = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ecl_lsu_valid_e && legal_op) begin
                    op_d     = ecl_lsu_op_e;
                    base_d   = ecl_lsu_base_e;
                    offset_d = ecl_lsu_offset_e;
                    wdata_d  = ecl_lsu_wdata_e;
                    state_d  = S_LS1;
                end
            end
            S_LS1: begin
                if (misaligned) begin
                    lsu_ecl_except_ale_ls1  = 1'b1;
                    lsu_csr_except_badv_ls1 = ls1_addr;
                    state_d                 = S_IDLE;
                end else begin
                    addr_d  = ls1_addr;
                    state_d = S_LS2;
                    // Request registers load here so they are valid on the
                    // first LS2 cycle.
                    if (is_store) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = ls1_addr;
                        wr_data_d = repl_data;
                        wr_strb_d = size_mask << ls1_addr[2:0];
                    end else begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = ls1_addr;
                    end
                end
            end
            S_LS2: begin
                if (is_store && biu.biu_lsu_wr_ack_ls2) begin
                    wr_req_d  = 1'b0;
                    wr_addr_d = 32'h0;
                    wr_data_d = 64'h0;
                    wr_strb_d = 8'h0;
                    state_d   = S_LS3;
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else if (!is_store && biu.biu_lsu_rd_ack_ls2) begin
                    rd_req_d  = 1'b0;
                    rd_addr_d = 32'h0;
                    state_d   = S_LS3;
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            S_LS3: begin
                if (done_ls3) begin
                    lsu_ecl_data_valid_ls3 = 1'b1;
                    lsu_ecl_data_ls3       = is_store ? 32'h0 : load_ext;
                    state_d                = S_IDLE;
                end
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
                // cnt_q counts completed LS3 cycles; the last allowed cycle
                // raises the error instead of waiting further.
                else if (cnt_q == CNT_LAST) begin
                    lsu_ecl_except_buserr_ls3 = 1'b1;
                    state_d                   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            op_q      <= 7'h0;
            base_q    <= 32'h0;
            offset_q  <= 32'h0;
            wdata_q   <= 32'h0;
            addr_q    <= 32'h0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= 32'h0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= 32'h0;
            wr_data_q <= 64'h0;
            wr_strb_q <= 8'h0;
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            base_q    <= base_d;
            offset_q  <= offset_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign biu.lsu_biu_rd_req_ls2  = rd_req_q;
    assign biu.lsu_biu_rd_addr_ls2 = rd_addr_q;
    assign biu.lsu_biu_wr_req_ls2  = wr_req_q;
    assign biu.lsu_biu_wr_addr_ls2 = wr_addr_q;
    assign biu.lsu_biu_wr_data_ls2 = wr_data_q;
    assign biu.lsu_biu_wr_strb_ls2 = wr_strb_q;
    assign lsu_ecl_except_ecc_ls3  = 1'b0;

endmodule

// File: tb/tb_c7b_lsu.sv
// ----------------------------------------------------------------------------
// tb_c7b_lsu
// Directed bench for c7b_lsu. Inputs change on the falling edge and outputs
// are sampled on the falling edge (or 1 ns after a combinational input change).
// Define C7BLSU_BUSERR_TIMEOUT_EN to exercise the timeout build.
// ----------------------------------------------------------------------------
module tb_c7b_lsu;

    logic        clk;
    logic        resetn;
    logic        ecl_lsu_valid_e;
    logic [6:0]  ecl_lsu_op_e;
    logic [31:0] ecl_lsu_base_e;
    logic [31:0] ecl_lsu_offset_e;
    logic [31:0] ecl_lsu_wdata_e;
    logic        lsu_ecl_data_valid_ls3;
    logic [31:0] lsu_ecl_data_ls3;
    logic        lsu_ecl_except_ale_ls1;
    logic [31:0] lsu_csr_except_badv_ls1;
    logic        lsu_ecl_except_buserr_ls3;
    logic        lsu_ecl_except_ecc_ls3;

    c7b_lsu_if bus ();

    c7b_lsu #(.BUSERR_TIMEOUT(256)) dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .ecl_lsu_valid_e           (ecl_lsu_valid_e),
        .ecl_lsu_op_e              (ecl_lsu_op_e),
        .ecl_lsu_base_e            (ecl_lsu_base_e),
        .ecl_lsu_offset_e          (ecl_lsu_offset_e),
        .ecl_lsu_wdata_e           (ecl_lsu_wdata_e),
        .lsu_ecl_data_valid_ls3    (lsu_ecl_data_valid_ls3),
        .lsu_ecl_data_ls3          (lsu_ecl_data_ls3),
        .lsu_ecl_except_ale_ls1    (lsu_ecl_except_ale_ls1),
        .lsu_csr_except_badv_ls1   (lsu_csr_except_badv_ls1),
        .lsu_ecl_except_buserr_ls3 (lsu_ecl_except_buserr_ls3),
        .lsu_ecl_except_ecc_ls3    (lsu_ecl_except_ecc_ls3),
        .biu                       (bus.master)
    );

    localparam logic [6:0] LD_B  = 7'h00;
    localparam logic [6:0] LD_H  = 7'h01;
    localparam logic [6:0] LD_W  = 7'h02;
    localparam logic [6:0] LD_BU = 7'h04;
    localparam logic [6:0] LD_HU = 7'h05;
    localparam logic [6:0] ST_B  = 7'h08;
    localparam logic [6:0] ST_H  = 7'h09;
    localparam logic [6:0] ST_W  = 7'h0A;
    localparam logic [63:0] RD64 = 64'h1234_5678_9ABC_DEF0;

    int tests_run    = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete operation: issue, LS1, LS2 (with ack_delay cycles of
    // back-pressure and a stray issue attempt), LS3 completion.
    task automatic run_op(input string tag, input logic [6:0] op,
                          input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] wdata, input logic [63:0] rdata,
                          input logic [31:0] exp_addr, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input logic [31:0] exp_data,
                          input int ack_delay);
        logic st;
        st = op[3];
        @(negedge clk);
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = op;
        ecl_lsu_base_e   = base;
        ecl_lsu_offset_e = off;
        ecl_lsu_wdata_e  = wdata;
        @(negedge clk);
        ecl_lsu_valid_e = 1'b0;
        check({tag, "_ls1_ale"}, lsu_ecl_except_ale_ls1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < ack_delay; i++) begin
            ecl_lsu_valid_e  = 1'b1;
            ecl_lsu_op_e     = LD_B;
            ecl_lsu_base_e   = 32'h0000_0777;
            if (st) check({tag, "_hold_wraddr"}, bus.lsu_biu_wr_addr_ls2, exp_addr);
            else    check({tag, "_hold_rdaddr"}, bus.lsu_biu_rd_addr_ls2, exp_addr);
            @(negedge clk);
        end
        ecl_lsu_valid_e = 1'b0;
        if (st) begin
            check({tag, "_wrreq"},  bus.lsu_biu_wr_req_ls2,  1'b1);
            check({tag, "_rdreq0"}, bus.lsu_biu_rd_req_ls2,  1'b0);
            check({tag, "_wraddr"}, bus.lsu_biu_wr_addr_ls2, exp_addr);
            check({tag, "_strb"},   bus.lsu_biu_wr_strb_ls2, exp_strb);
            check({tag, "_wrdata"}, bus.lsu_biu_wr_data_ls2, exp_wdata);
            bus.biu_lsu_wr_ack_ls2 = 1'b1;
        end else begin
            check({tag, "_rdreq"},  bus.lsu_biu_rd_req_ls2,  1'b1);
            check({tag, "_wrreq0"}, bus.lsu_biu_wr_req_ls2,  1'b0);
            check({tag, "_rdaddr"}, bus.lsu_biu_rd_addr_ls2, exp_addr);
            bus.biu_lsu_rd_ack_ls2 = 1'b1;
        end
        @(negedge clk);
        bus.biu_lsu_rd_ack_ls2 = 1'b0;
        bus.biu_lsu_wr_ack_ls2 = 1'b0;
        check({tag, "_req_drop"}, {bus.lsu_biu_rd_req_ls2, bus.lsu_biu_wr_req_ls2}, 2'b00);
        check({tag, "_dv_early"}, lsu_ecl_data_valid_ls3, 1'b0);
        if (st) bus.biu_lsu_wr_done_ls3 = 1'b1;
        else begin
            bus.biu_lsu_data_valid_ls3 = 1'b1;
            bus.biu_lsu_data_ls3       = rdata;
        end
        #1;
        check({tag, "_dv"},   lsu_ecl_data_valid_ls3, 1'b1);
        check({tag, "_data"}, lsu_ecl_data_ls3,       exp_data);
        @(negedge clk);
        bus.biu_lsu_wr_done_ls3    = 1'b0;
        bus.biu_lsu_data_valid_ls3 = 1'b0;
        #1;
        check({tag, "_dv_once"}, lsu_ecl_data_valid_ls3, 1'b0);
        @(negedge clk);
        check({tag, "_idle_noreq"}, {bus.lsu_biu_rd_req_ls2, bus.lsu_biu_wr_req_ls2}, 2'b00);
    endtask

    int ale_cnt;
    int req_seen;
    int dv_cnt;
    int berr_cnt;
    int berr_at;
    logic [31:0] badv_seen;
    logic badv_leak;

    initial begin
        resetn                     = 1'b0;
        ecl_lsu_valid_e            = 1'b0;
        ecl_lsu_op_e               = 7'h0;
        ecl_lsu_base_e             = 32'h0;
        ecl_lsu_offset_e           = 32'h0;
        ecl_lsu_wdata_e            = 32'h0;
        bus.biu_lsu_rd_ack_ls2     = 1'b0;
        bus.biu_lsu_data_valid_ls3 = 1'b0;
        bus.biu_lsu_data_ls3       = 64'h0;
        bus.biu_lsu_wr_ack_ls2     = 1'b0;
        bus.biu_lsu_wr_done_ls3    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ecl_outs", {lsu_ecl_data_valid_ls3, lsu_ecl_data_ls3, lsu_ecl_except_ale_ls1,
                               lsu_ecl_except_buserr_ls3, lsu_ecl_except_ecc_ls3}, 36'h0);
        check("rst_badv", lsu_csr_except_badv_ls1, 32'h0);
        check("rst_rd", {bus.lsu_biu_rd_req_ls2, bus.lsu_biu_rd_addr_ls2}, 33'h0);
        check("rst_wr_req_addr", {bus.lsu_biu_wr_req_ls2, bus.lsu_biu_wr_addr_ls2,
                                  bus.lsu_biu_wr_strb_ls2}, 41'h0);
        check("rst_wr_data", bus.lsu_biu_wr_data_ls2, 64'h0);
        resetn = 1'b1;

        run_op("ldw",    LD_W,  32'h1000, 32'h4, 32'h0, RD64, 32'h1004, 8'h0, 64'h0, 32'h1234_5678, 0);
        run_op("ldb",    LD_B,  32'h1000, 32'h0, 32'h0, RD64, 32'h1000, 8'h0, 64'h0, 32'hFFFF_FFF0, 0);
        run_op("ldbu",   LD_BU, 32'h1000, 32'h0, 32'h0, RD64, 32'h1000, 8'h0, 64'h0, 32'h0000_00F0, 0);
        run_op("ldh6",   LD_H,  32'h1000, 32'h6, 32'h0, RD64, 32'h1006, 8'h0, 64'h0, 32'h0000_1234, 0);
        run_op("ldh2",   LD_H,  32'h1000, 32'h2, 32'h0, RD64, 32'h1002, 8'h0, 64'h0, 32'hFFFF_9ABC, 0);
        run_op("ldhu2",  LD_HU, 32'h1000, 32'h2, 32'h0, RD64, 32'h1002, 8'h0, 64'h0, 32'h0000_9ABC, 0);
        run_op("ldwrap", LD_B,  32'hFFFF_FFFF, 32'h2, 32'h0, RD64, 32'h0000_0001, 8'h0, 64'h0,
               32'hFFFF_FFDE, 0);
        run_op("stb",    ST_B,  32'h2000, 32'h2, 32'hAA, 64'h0, 32'h2002, 8'h04,
               64'hAAAA_AAAA_AAAA_AAAA, 32'h0, 0);
        run_op("sth",    ST_H,  32'h2000, 32'h6, 32'h1234_BEEF, 64'h0, 32'h2006, 8'hC0,
               64'hBEEF_BEEF_BEEF_BEEF, 32'h0, 0);
        run_op("stw_dly", ST_W, 32'h2000, 32'h4, 32'hDEAD_BEEF, 64'h0, 32'h2004, 8'hF0,
               64'hDEAD_BEEF_DEAD_BEEF, 32'h0, 3);
        run_op("ldw_dly", LD_W, 32'h1000, 32'h4, 32'h0, RD64, 32'h1004, 8'h0, 64'h0, 32'h1234_5678, 3);

        // Misaligned word load, valid held for two cycles.
        @(negedge clk);
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = LD_W;
        ecl_lsu_base_e   = 32'h3001;
        ecl_lsu_offset_e = 32'h0;
        ale_cnt = 0; req_seen = 0; badv_seen = 32'h0; badv_leak = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) ecl_lsu_valid_e = 1'b0;
            if (lsu_ecl_except_ale_ls1) begin
                ale_cnt++;
                badv_seen = lsu_csr_except_badv_ls1;
            end else if (lsu_csr_except_badv_ls1 != 32'h0) badv_leak = 1'b1;
            if (bus.lsu_biu_rd_req_ls2 || bus.lsu_biu_wr_req_ls2) req_seen++;
        end
        check("ale_pulses", ale_cnt, 1);
        check("ale_badv", badv_seen, 32'h3001);
        check("ale_badv_zero_else", badv_leak, 1'b0);
        check("ale_no_req", req_seen, 0);

        // Illegal opcode is ignored.
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = 7'h03;
        ecl_lsu_base_e   = 32'h1000;
        req_seen = 0; ale_cnt = 0;
        @(negedge clk);
        ecl_lsu_valid_e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.lsu_biu_rd_req_ls2 || bus.lsu_biu_wr_req_ls2) req_seen++;
            if (lsu_ecl_except_ale_ls1) ale_cnt++;
            @(negedge clk);
        end
        check("illegal_no_req", req_seen, 0);
        check("illegal_no_ale", ale_cnt, 0);

        // Reset in LS2 aborts; a late ack and data are then ignored.
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = LD_W;
        ecl_lsu_base_e   = 32'h5000;
        ecl_lsu_offset_e = 32'h0;
        @(negedge clk);
        ecl_lsu_valid_e = 1'b0;
        @(negedge clk);
        check("abort_rdreq_before", bus.lsu_biu_rd_req_ls2, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort_rdreq_after", {bus.lsu_biu_rd_req_ls2, bus.lsu_biu_rd_addr_ls2}, 33'h0);
        bus.biu_lsu_rd_ack_ls2     = 1'b1;
        bus.biu_lsu_data_valid_ls3 = 1'b1;
        bus.biu_lsu_data_ls3       = RD64;
        dv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (lsu_ecl_data_valid_ls3) dv_cnt++;
            @(negedge clk);
        end
        bus.biu_lsu_rd_ack_ls2     = 1'b0;
        bus.biu_lsu_data_valid_ls3 = 1'b0;
        check("abort_no_complete", dv_cnt, 0);

        // LS3 with no response for 300 cycles.
        ecl_lsu_valid_e  = 1'b1;
        ecl_lsu_op_e     = LD_W;
        ecl_lsu_base_e   = 32'h4000;
        ecl_lsu_offset_e = 32'h8;
        @(negedge clk);
        ecl_lsu_valid_e = 1'b0;
        @(negedge clk);
        check("to_rdreq", bus.lsu_biu_rd_req_ls2, 1'b1);
        bus.biu_lsu_rd_ack_ls2 = 1'b1;
        @(negedge clk);
        bus.biu_lsu_rd_ack_ls2 = 1'b0;
        berr_cnt = 0; berr_at = 0; dv_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            if (lsu_ecl_except_buserr_ls3) begin
                berr_cnt++;
                berr_at = i;
            end
            if (lsu_ecl_data_valid_ls3) dv_cnt++;
            @(negedge clk);
        end
        check("to_no_dv", dv_cnt, 0);
`ifdef C7BLSU_BUSERR_TIMEOUT_EN
        check("to_berr_pulses", berr_cnt, 1);
        check("to_berr_cycle", berr_at, 256);
`else
        check("to_berr_pulses", berr_cnt, 0);
        bus.biu_lsu_data_valid_ls3 = 1'b1;
        bus.biu_lsu_data_ls3       = RD64;
        #1;
        check("to_late_dv", lsu_ecl_data_valid_ls3, 1'b1);
        check("to_late_data", lsu_ecl_data_ls3, 32'h9ABC_DEF0);
        @(negedge clk);
        bus.biu_lsu_data_valid_ls3 = 1'b0;
`endif
        run_op("post", LD_HU, 32'h1000, 32'h6, 32'h0, RD64, 32'h1006, 8'h0, 64'h0, 32'h0000_1234, 1);
        check("ecc_zero", lsu_ecl_except_ecc_ls3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
